// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_DEFAULT_LATENCY = 3;
    localparam int DMEM_WORD_WIDTH      = 32;

    // Request sequencing: wait states in BUSY, one-cycle completion in DONE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : MEM-stage request/response bundle between requester and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic                       MemRead;
    logic                       MemWrite;
    logic [DMEM_WORD_WIDTH-1:0] Address;
    logic [DMEM_WORD_WIDTH-1:0] WriteData;
    logic [DMEM_WORD_WIDTH-1:0] ReadData;
    logic                       MemReady;
    logic                       MemError;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, MemReady, MemError
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, MemReady, MemError
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : 2^ADDR_WIDTH x 32 word storage, synchronous write, async read.
//            Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       we,
    input  wire logic [ADDR_WIDTH-1:0]      addr,
    input  wire logic [DMEM_WORD_WIDTH-1:0] wdata,
    output logic      [DMEM_WORD_WIDTH-1:0] rdata
);

    logic [DMEM_WORD_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Word write on the access edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Multi-cycle data-memory responder. Accepts one word read/write,
//            waits LATENCY cycles, performs the access and pulses MemReady.
//            Optional macro DMEM_ALIGN_CHECK_EN: misaligned requests skip the
//            array access and complete with MemError.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = DMEM_DEFAULT_LATENCY
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    data_mem_responder_if.slave bus
);

    localparam logic [7:0] c_cnt_load = 8'(LATENCY - 1);

    dmem_state_t                r_state;
    dmem_state_t                w_next_state;
    logic [7:0]                 r_cnt;
    logic                       r_is_write;
    logic                       r_misaligned;
    logic                       r_error;
    logic [ADDR_WIDTH-1:0]      r_index;
    logic [DMEM_WORD_WIDTH-1:0] r_wdata;
    logic [DMEM_WORD_WIDTH-1:0] r_rdata;
    logic [DMEM_WORD_WIDTH-1:0] w_array_rdata;
    logic                       w_accept;
    logic                       w_access;
    logic                       w_array_we;
    logic                       w_misaligned_in;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned_in = |bus.Address[1:0];
`else
    assign w_misaligned_in = 1'b0;
`endif

    // Upper address bits alias; low byte-offset bits matter only to the check
    wire w_unused_addr_bits = ^{bus.Address[DMEM_WORD_WIDTH-1:ADDR_WIDTH+2],
                                bus.Address[1:0]};

    // Next-state and per-cycle strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_access     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset wins over acceptance on the same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch, wait counter and load-data register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt        <= 8'd0;
            r_is_write   <= 1'b0;
            r_misaligned <= 1'b0;
            r_error      <= 1'b0;
            r_index      <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt        <= c_cnt_load;
                r_is_write   <= bus.MemWrite;
                r_misaligned <= w_misaligned_in;
                r_index      <= bus.Address[ADDR_WIDTH+1:2];
                r_wdata      <= bus.WriteData;
            end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_access) begin
                r_error <= r_misaligned;
                if (!r_is_write && !r_misaligned) begin
                    r_rdata <= w_array_rdata;
                end
            end
        end
    end

    // A reset on the access edge must also drop the pending write
    assign w_array_we = w_access && r_is_write && !r_misaligned && !Reset;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (Clk),
        .we    (w_array_we),
        .addr  (r_index),
        .wdata (r_wdata),
        .rdata (w_array_rdata)
    );

    assign bus.MemReady = (r_state == S_DONE);
    assign bus.MemError = (r_state == S_DONE) && r_error;
    assign bus.ReadData = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder (ADDR_WIDTH=8,
//            LATENCY=3). Honours DMEM_ALIGN_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int AW  = 8;
    localparam int LAT = 3;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem_model [2**AW];
    logic [31:0] rd_model;
    vec_t        tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour of one completed request
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
        logic mis;
        int   idx;
        mis = ALIGN && (addr[1:0] != 2'b00);
        idx = int'(addr[AW+1:2]);
        if (wr) begin
            if (!mis) mem_model[idx] = data;
        end else if (rd && !mis) begin
            rd_model = mem_model[idx];
        end
    endtask

    // One full transaction: drive, hold (with scrambled address/data), check
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rdata,
                          input logic exp_err, input string name);
        int n;
        n = -1;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = data;
        @(posedge clk);
        for (int i = 0; i <= LAT + 4; i++) begin
            #1;
            if (bus.MemReady) begin
                n = i;
                break;
            end
            bus.Address   = $urandom;
            bus.WriteData = $urandom;
            @(posedge clk);
        end
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        check({name, " latency"}, n, LAT);
        check({name, " ReadData"}, bus.ReadData, exp_rdata);
        check({name, " MemError"}, {31'd0, bus.MemError}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        check({name, " pulse width"}, {31'd0, bus.MemReady}, 32'd0);
    endtask

    initial begin
        logic        rd, wr, seen;
        logic [31:0] addr, data;

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'd32,        32'd0,        1'b0, "wr 0"};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0000, 32'd0,         32'd32,       1'b0, "rd 0"};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEADBEEF,  32'd32,       1'b0, "wr 0x400"};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'd0,         32'hDEADBEEF, 1'b0, "rd alias"};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0004, 32'd7,         32'hDEADBEEF, 1'b0, "rd+wr 4"};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'd0,         32'd7,        1'b0, "rd 4"};
        if (ALIGN) tbl[6] = '{1'b1, 1'b0, 32'h2, 32'd0, 32'd7,        1'b1, "rd misaligned"};
        else       tbl[6] = '{1'b1, 1'b0, 32'h2, 32'd0, 32'hDEADBEEF, 1'b0, "rd misaligned"};

        rst           = 1'b1;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        rd_model      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset MemReady", {31'd0, bus.MemReady}, 32'd0);
        check("reset MemError", {31'd0, bus.MemError}, 32'd0);
        check("reset ReadData", bus.ReadData, 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                   tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].name);
        end

        // Reset in the second BUSY cycle drops the write
        model_apply(1'b0, 1'b1, 32'h8, 32'h11);
        access(1'b0, 1'b1, 32'h8, 32'h11, rd_model, 1'b0, "wr 8");
        bus.MemWrite = 1'b1; bus.Address = 32'h8; bus.WriteData = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rd_model = '0;
        check("abort ReadData", bus.ReadData, 32'd0);
        seen = bus.MemReady;
        repeat (LAT + 2) begin @(posedge clk); #1; seen |= bus.MemReady; end
        check("abort busy no ready", {31'd0, seen}, 32'd0);

        // Reset exactly on the access edge also drops the write
        bus.MemWrite = 1'b1; bus.Address = 32'h8; bus.WriteData = 32'h66;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1;
        rst = 1'b1; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort access-edge ready", {31'd0, bus.MemReady}, 32'd0);
        model_apply(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 32'h11, 1'b0, "rd 8 after abort");

        // Reset during DONE drops MemReady; reset beats a request on that edge
        bus.MemRead = 1'b1; bus.Address = 32'h4;
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("done before reset", {31'd0, bus.MemReady}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset in DONE ready", {31'd0, bus.MemReady}, 32'd0);
        check("reset in DONE ReadData", bus.ReadData, 32'd0);
        rst = 1'b0; bus.MemRead = 1'b0; rd_model = '0;
        seen = 1'b0;
        repeat (LAT + 2) begin @(posedge clk); #1; seen |= bus.MemReady; end
        check("reset beats accept", {31'd0, seen}, 32'd0);

        // Randomized: prefill every word, then random mixed traffic
        for (int i = 0; i < 2**AW; i++) begin
            addr = {$urandom_range(0, 255), 14'd0, 8'(i), 2'b00};
            data = $urandom;
            model_apply(1'b0, 1'b1, addr, data);
            access(1'b0, 1'b1, addr, data, rd_model, 1'b0, "prefill");
        end
        for (int i = 0; i < 200; i++) begin
            rd   = 1'($urandom);
            wr   = ($urandom_range(0, 2) == 0);
            if (!rd && !wr) rd = 1'b1;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            data = $urandom;
            model_apply(rd, wr, addr, data);
            access(rd, wr, addr, data, rd_model, ALIGN && (addr[1:0] != 2'b00), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
